// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
//   parity_e   : parity mode encoding carried with each queued word
//   tx_state_e : transmitter frame states
//   frame_len  : number of bit periods in one frame for a given configuration
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int unsigned frame_len(input int unsigned data_bits,
                                            input logic        par_en,
                                            input logic        stop2);
    return 1 + data_bits + (par_en ? 1 : 0) + (stop2 ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding register.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clk_en      : one-cycle tick per bit period
//   s_data      : word to send (DATA_BITS wide)
//   s_parity    : 0 none, 1 even, 2 odd, 3 treated as none
//   s_stop2     : 1 = two stop bits
//   s_valid     : input word valid; transfer when s_valid && s_ready
//   s_ready     : holding register empty
//   busy        : frame in progress or holding register full
//   done        : one-cycle pulse at the end of each frame's last stop bit
//   tx_out      : registered serial line
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int   DATA_BITS  = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic [1:0]           s_parity,
  input  logic                 s_stop2,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 tx_out
);

  // Wide enough to hold the value DATA_BITS itself, so 9 does not wrap.
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  tx_state_e            state_q, state_d;
  logic                 hold_full_q, hold_full_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic [1:0]           hold_par_q, hold_par_d;
  logic                 hold_stop2_q, hold_stop2_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_cnt_q, stop_cnt_d;

  logic                 accept;
  logic                 load;

  // Ready is simply "holding register empty", so accept and unload can
  // never coincide: accept needs it empty, unload needs it full.
  assign accept = s_valid && !hold_full_q;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    hold_full_d  = hold_full_q;
    tx_d         = tx_q;
    done_d       = 1'b0;
    hold_data_d  = hold_data_q;
    hold_par_d   = hold_par_q;
    hold_stop2_d = hold_stop2_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_en_d     = par_en_q;
    par_bit_d    = par_bit_q;
    stop2_d      = stop2_q;
    stop_cnt_d   = stop_cnt_q;
    load         = 1'b0;

    if (accept) begin
      hold_full_d  = 1'b1;
      hold_data_d  = s_data;
      hold_par_d   = s_parity;
      hold_stop2_d = s_stop2;
    end

    if (clk_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (hold_full_q) load = 1'b1;
        end
        ST_START: begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = CNT_W'(1);
        end
        ST_DATA: begin
          if (bit_cnt_q == CNT_W'(DATA_BITS)) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              tx_d       = IDLE_LEVEL;
              stop_cnt_d = 1'b0;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          state_d    = ST_STOP;
          tx_d       = IDLE_LEVEL;
          stop_cnt_d = 1'b0;
        end
        ST_STOP: begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d = 1'b1;
            // A queued word starts immediately, leaving no idle gap.
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = IDLE_LEVEL;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = IDLE_LEVEL;
        end
      endcase
    end

    // Parity is fixed from the whole word here, before any shifting.
    if (load) begin
      state_d     = ST_START;
      tx_d        = ~IDLE_LEVEL;
      hold_full_d = 1'b0;
      shift_d     = hold_data_q;
      par_en_d    = (hold_par_q == PAR_EVEN) || (hold_par_q == PAR_ODD);
      par_bit_d   = (^hold_data_q) ^ (hold_par_q == PAR_ODD);
      stop2_d     = hold_stop2_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      tx_q        <= IDLE_LEVEL;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  // NOTE: payload registers carry no reset; they are always written before
  // being read, guarded by hold_full_q or the frame state.
  always_ff @(posedge clk) begin
    hold_data_q  <= hold_data_d;
    hold_par_q   <= hold_par_d;
    hold_stop2_q <= hold_stop2_d;
    shift_q      <= shift_d;
    bit_cnt_q    <= bit_cnt_d;
    par_en_q     <= par_en_d;
    par_bit_q    <= par_bit_d;
    stop2_q      <= stop2_d;
    stop_cnt_q   <= stop_cnt_d;
  end

  assign s_ready = !hold_full_q;
  assign busy    = (state_q != ST_IDLE) || hold_full_q;
  assign done    = done_q;
  assign tx_out  = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: an 8-bit instance with a tick every
// 4 clocks (frame monitor + scoreboard) and a 9-bit instance with the tick
// tied high.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       clk_en8   = 1'b0;
  logic [7:0] s_data8   = '0;
  logic [1:0] s_parity8 = '0;
  logic       s_stop28  = 1'b0;
  logic       s_valid8  = 1'b0;
  logic       s_ready8, busy8, done8, tx8;

  // 9-bit instance
  logic       clk_en9   = 1'b1;
  logic [8:0] s_data9   = '0;
  logic [1:0] s_parity9 = '0;
  logic       s_stop29  = 1'b0;
  logic       s_valid9  = 1'b0;
  logic       s_ready9, busy9, done9, tx9;

  uart_tx_cfg #(.DATA_BITS(8), .IDLE_LEVEL(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en8), .s_data(s_data8),
    .s_parity(s_parity8), .s_stop2(s_stop28), .s_valid(s_valid8),
    .s_ready(s_ready8), .busy(busy8), .done(done8), .tx_out(tx8));

  uart_tx_cfg #(.DATA_BITS(9), .IDLE_LEVEL(1'b1)) dut9 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en9), .s_data(s_data9),
    .s_parity(s_parity9), .s_stop2(s_stop29), .s_valid(s_valid9),
    .s_ready(s_ready9), .busy(busy9), .done(done9), .tx_out(tx9));

  typedef struct {
    logic [7:0] data;
    logic [1:0] par;
    logic       stop2;
    logic       par_en;   // expected: parity bit present
    logic       par_val;  // expected parity bit value
    int         len;      // expected frame length in bit periods
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Expected line image: start 0, data LSB first, optional parity, stops 1.
  function automatic logic [12:0] build(input vec_t v);
    logic [12:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = v.data[i];
    if (v.par_en) f[9] = v.par_val;
    return f;
  endfunction

  // ---------------- frame monitor / scoreboard for dut8 ----------------
  vec_t        sb8[$];
  int          starts8[$];
  int          dones8[$];
  int          frames8   = 0;
  int          done_cnt8 = 0;
  logic        done_prev8 = 1'b0;
  logic        mon_en    = 1'b1;
  bit          in_frame  = 1'b0;
  int          bcnt      = 0;
  int          start_cyc = 0;
  int          div       = 0;
  logic [12:0] got       = '1;
  vec_t        cur;

  always @(negedge clk) begin
    if (done8) begin
      check("done_one_cycle", done_prev8, 1'b0);
      done_cnt8++;
      dones8.push_back(cyc);
    end
    done_prev8 = done8;

    if (!rst_n) in_frame = 1'b0;
    // clk_en8 still holds the value it had at the last rising edge.
    if (mon_en && rst_n && clk_en8) begin
      if (!in_frame) begin
        if (tx8 == 1'b0) begin
          if (sb8.size() == 0) begin
            timeout("unexpected_frame");
          end else begin
            cur       = sb8.pop_front();
            in_frame  = 1'b1;
            got       = '1;
            got[0]    = tx8;
            bcnt      = 1;
            start_cyc = cyc;
          end
        end
      end else begin
        got[bcnt] = tx8;
        bcnt++;
        if (bcnt == cur.len) begin
          check("frame_bits", got, build(cur));
          starts8.push_back(start_cyc);
          frames8++;
          in_frame = 1'b0;
        end
      end
    end

    div     = (div + 1) % 4;
    clk_en8 = (div == 0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send8(input vec_t v, input bit drop, input bit push);
    int n = 0;
    step();
    s_data8   = v.data;
    s_parity8 = v.par;
    s_stop28  = v.stop2;
    s_valid8  = 1'b1;
    while (!s_ready8 && n < 500) begin
      step();
      n++;
    end
    if (!s_ready8) timeout("send8_ready");
    if (push) sb8.push_back(v);
    @(posedge clk);
    if (drop) begin
      step();
      s_valid8 = 1'b0;
    end
  endtask

  task automatic wait_done8(input int target);
    int n = 0;
    while (done_cnt8 < target && n < 2000) begin
      step();
      n++;
    end
    if (done_cnt8 < target) timeout("wait_done8");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t        tbl[7];
  vec_t        v00, vff, v3c2;
  int          d0, f0, n;
  logic [11:0] exp9;

  initial begin
    //            data   par   stop2 par_en par_val len
    tbl[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 10};
    tbl[1] = '{8'hA5, 2'd1, 1'b0, 1'b1, 1'b0, 11};
    tbl[2] = '{8'hA5, 2'd2, 1'b0, 1'b1, 1'b1, 11};
    tbl[3] = '{8'h3C, 2'd0, 1'b1, 1'b0, 1'b0, 11};
    tbl[4] = '{8'h01, 2'd1, 1'b1, 1'b1, 1'b1, 12};
    tbl[5] = '{8'h7F, 2'd2, 1'b0, 1'b1, 1'b0, 11};
    tbl[6] = '{8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 10};
    v00    = '{8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 10};
    vff    = '{8'hFF, 2'd0, 1'b0, 1'b0, 1'b0, 10};
    v3c2   = '{8'h3C, 2'd0, 1'b1, 1'b0, 1'b0, 11};

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_tx8", tx8, 1'b1);
    check("rst_ready8", s_ready8, 1'b1);
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_tx9", tx9, 1'b1);
    check("rst_ready9", s_ready9, 1'b1);
    rst_n = 1'b1;
    step();

    // Single frames from the vector table
    for (int i = 0; i < 7; i++) begin
      d0 = done_cnt8;
      f0 = frames8;
      send8(tbl[i], 1'b1, 1'b1);
      wait_done8(d0 + 1);
      check("frame_count", frames8, f0 + 1);
      check("busy_after", busy8, 1'b0);
      check("ready_after", s_ready8, 1'b1);
      check("done_timing", dones8[$] - starts8[$], tbl[i].len * 4);
    end

    // Back-to-back with s_valid held high
    d0 = done_cnt8;
    send8(v00, 1'b0, 1'b1);
    step();
    check("b2b_ready_low1", s_ready8, 1'b0);
    check("b2b_busy", busy8, 1'b1);
    send8(vff, 1'b1, 1'b1);
    check("b2b_ready_low2", s_ready8, 1'b0);
    wait_done8(d0 + 2);
    check("b2b_start_gap", starts8[$] - starts8[$-1], 40);
    check("b2b_done_gap", dones8[$] - dones8[$-1], 40);
    check("b2b_busy_end", busy8, 1'b0);

    // Two stop bits followed by a queued word
    d0 = done_cnt8;
    send8(v3c2, 1'b0, 1'b1);
    send8(tbl[0], 1'b1, 1'b1);
    wait_done8(d0 + 2);
    check("stop2_start_gap", starts8[$] - starts8[$-1], 44);

    // Reset during the 4th data bit
    mon_en = 1'b0;
    d0     = done_cnt8;
    send8(tbl[0], 1'b1, 1'b0);
    n = 0;
    while (tx8 !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    if (tx8 !== 1'b0) timeout("abort_start");
    repeat (17) step();
    check("abort_busy_pre", busy8, 1'b1);
    rst_n = 1'b0;
    step();
    check("abort_tx", tx8, 1'b1);
    check("abort_ready", s_ready8, 1'b1);
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    step();
    rst_n = 1'b1;
    repeat (24) step();
    check("abort_no_done", done_cnt8, d0);
    check("abort_line_idle", tx8, 1'b1);
    mon_en = 1'b1;
    f0 = frames8;
    send8(tbl[5], 1'b1, 1'b1);
    wait_done8(d0 + 1);
    check("post_abort_frame", frames8, f0 + 1);

    // 9-bit instance, tick tied high, 0x1FF odd parity
    exp9 = 12'hBFE;  // period 0 at bit 0: start 0, nine 1s, parity 0, stop 1
    step();
    s_data9   = 9'h1FF;
    s_parity9 = 2'd2;
    s_stop29  = 1'b0;
    s_valid9  = 1'b1;
    @(posedge clk);
    step();
    s_valid9 = 1'b0;
    n = 0;
    while (tx9 !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    if (tx9 !== 1'b0) timeout("dut9_start");
    for (int k = 0; k < int'(frame_len(9, 1'b1, 1'b0)); k++) begin
      check($sformatf("dut9_bit%0d", k), tx9, exp9[k]);
      step();
    end
    check("dut9_done", done9, 1'b1);
    check("dut9_idle", tx9, 1'b1);
    check("dut9_busy", busy9, 1'b0);
    step();
    check("dut9_done_clear", done9, 1'b0);

    check("sb_empty", sb8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmit block. Serialises words of DATA_BITS width with run-time selectable parity (none/even/odd) and 1 or 2 stop bits. Uses a valid/ready input handshake and a one-entry holding register so back-to-back frames go out with no idle gap. Bit timing comes from an external one-cycle-per-bit-period tick (clk_en) from the existing baud tick generator.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
IDLE_LEVEL, 1'b1, line level in idle and stop bits; start bit is the inverse.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous reset, active-low.
clk_en  input  1  bit-period tick, one-cycle pulse per bit period.
s_data  input  DATA_BITS  word to send.
s_parity  input  2  parity mode latched with s_data: 0 none, 1 even, 2 odd, 3 reserved (treated as none).
s_stop2  input  1  latched with s_data: 1 = two stop bits, 0 = one.
s_valid  input  1  s_data/s_parity/s_stop2 valid.
s_ready  output  1  holding register empty; transfer when s_valid && s_ready.
busy  output  1  frame in progress (state != IDLE) or holding register full.
done  output  1  one-cycle pulse at the end of each frame's last stop bit.
tx_out  output  1  serial line, registered.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, holding register empty, tx_out=IDLE_LEVEL, done=0, s_ready=1, busy=0. s_valid is ignored while rst_n=0. Reset mid-frame aborts it; the line returns to idle on the next edge, and no done is produced.
- Accept: s_valid && s_ready captures data plus config into the holding register. s_ready is registered: it drops the cycle after the accept. It rises the cycle after the holding register unloads into the shifter. There is no same-cycle unload-and-accept.
- States: IDLE, START, DATA, PARITY, STOP. All transitions occur only on cycles with clk_en=1. tx_out is updated on the same edge as the transition.
- IDLE: on clk_en with the holding register full, load the shifter and config, empty the holding register, go to START, tx_out<=~IDLE_LEVEL. The latency from accept to start-bit edge is 1..(tick period+1) cycles.
- START: on clk_en, go to DATA and drive bit 0 of the data, LSB first.
- DATA: each clk_en shifts right and drives the next bit. After DATA_BITS bits are sent, go to PARITY if parity is enabled, else to STOP.
- Parity bit: even gives XOR of the data bits; odd gives its inverse. Computed at shifter load, not from the shifted value.
- STOP: drive IDLE_LEVEL for 1 or 2 bit periods per the latched s_stop2.
- End of the final stop bit (on clk_en): pulse done=1 for exactly one clk cycle. If the holding register is full, go directly to START (tx_out<=~IDLE_LEVEL, no idle gap). Otherwise go to IDLE.
- Frame length: 1 + DATA_BITS + (parity?1:0) + (stop2?2:1) bit periods.
- Bit counter width: $clog2(DATA_BITS+1). The counter must not wrap for DATA_BITS=9.
- clk_en held high continuously is legal: one bit per clk cycle.
- Config changes after accept do not affect queued or in-flight frames.

Decomposition:
- Shared package uart_pkg: parity_e enum (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2), tx_state_e enum for the five states, and a helper function for frame length in bits.
- No sub-module. The baud tick stays in the existing generator outside this block.

Test Plan:
- DATA_BITS=8, clk_en every 4 clks, 0xA5, no parity, 1 stop -> tx_out per bit period 0,1,0,1,0,0,1,0,1,1; done pulses once, 4 clks after the stop bit starts; busy low afterwards.
- 0xA5 with even parity -> parity bit 0; with odd -> parity bit 1; frame is 11 bit periods.
- Back-to-back: 0x00 then 0xFF offered with s_valid held high -> second start bit directly follows the first stop bit; 20 contiguous bit periods; two done pulses exactly 10 bit periods apart; s_ready low while the holding register is full.
- s_stop2=1, 0x3C, then a second word queued -> stop is high for exactly 2 bit periods before the next start bit.
- rst_n=0 during the 4th data bit -> next edge tx_out=1, done never pulses, s_ready=1, busy=0. A new word after release is sent as a clean frame.
- DATA_BITS=9, clk_en tied high, 0x1FF, odd parity -> 12 consecutive clk cycles: 0, nine 1s, parity 0, stop 1.
